// File: rtl/xalu.sv
// Multiply/divide unit for the E stage: owns HI/LO and runs MULT/MULTU/DIV/DIVU
// with fixed multi-cycle latency, committing results when the countdown ends.
module xalu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  XALUOp_E,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] XALU_out,
    output logic        o_dbg_run
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] LAT_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] LAT_DIV  = 4'(DIV_CYCLES);

    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic        r_pend_valid;

    logic        w_idle, w_start, w_is_mul, w_div0;
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_neg_a, w_neg_b;
    logic [31:0] w_abs_a, w_abs_b, w_dvsr_s, w_mag_q, w_mag_r, w_sq, w_sr;
    logic [31:0] w_dvsr_u, w_uq, w_ur;
    logic [31:0] w_res_hi, w_res_lo;

    // Handshake: an op 1-4 is accepted (Start) only when idle; Busy acts as
    // not-ready for the D-stage hazard unit and covers the accept cycle too.
    assign w_idle   = (r_cnt == 4'd0);
    assign w_start  = (XALUOp_E >= OP_MULT) && (XALUOp_E <= OP_DIVU) && w_idle;
    assign w_is_mul = (XALUOp_E == OP_MULT) || (XALUOp_E == OP_MULTU);
    assign w_div0   = !w_is_mul && (B == 32'd0);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign w_neg_a  = A[31];
    assign w_neg_b  = B[31];
    assign w_abs_a  = w_neg_a ? -A : A;
    assign w_abs_b  = w_neg_b ? -B : B;
    assign w_dvsr_s = (B == 32'd0) ? 32'd1 : w_abs_b;
    assign w_mag_q  = w_abs_a / w_dvsr_s;
    assign w_mag_r  = w_abs_a % w_dvsr_s;
    assign w_sq     = (w_neg_a ^ w_neg_b) ? -w_mag_q : w_mag_q;
    assign w_sr     = w_neg_a ? -w_mag_r : w_mag_r;

    assign w_dvsr_u = (B == 32'd0) ? 32'd1 : B;
    assign w_uq     = A / w_dvsr_u;
    assign w_ur     = A % w_dvsr_u;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (XALUOp_E)
            OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
            OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
            OP_DIV:   begin w_res_hi = w_sr;            w_res_lo = w_sq;           end
            OP_DIVU:  begin w_res_hi = w_ur;            w_res_lo = w_uq;           end
            default:  ;
        endcase
    end

    // State register: the countdown is the IDLE/RUN state.
    always_ff @(posedge clk) begin
        if (reset) r_cnt <= 4'd0;
        else       r_cnt <= w_cnt_next;
    end

    // Next-state logic.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_start)     w_cnt_next = w_is_mul ? LAT_MULT : LAT_DIV;
        else if (!w_idle) w_cnt_next = r_cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_pend_hi    <= 32'd0;
            r_pend_lo    <= 32'd0;
            r_pend_valid <= 1'b0;
        end else if (w_start) begin
            r_pend_hi    <= w_res_hi;
            r_pend_lo    <= w_res_lo;
            r_pend_valid <= !w_div0;
        end else if (r_cnt == 4'd1) begin
            if (r_pend_valid) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            r_pend_valid <= 1'b0;
        end else if (w_idle && XALUOp_E == OP_MTHI) begin
            r_hi <= A;
        end else if (w_idle && XALUOp_E == OP_MTLO) begin
            r_lo <= A;
        end
    end

    // Output logic.
    always_comb begin
        Start     = w_start;
        Busy      = w_start || !w_idle;
        o_dbg_run = !w_idle;
        HI        = r_hi;
        LO        = r_lo;
        case (XALUOp_E)
            OP_MFHI: XALU_out = r_hi;
            OP_MFLO: XALU_out = r_lo;
            default: XALU_out = 32'd0;
        endcase
    end
endmodule

// File: doc/xalu.md
Name: xalu

Overview:
- Multiply/divide execution unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO with multi-cycle latency.
- Drives Busy, which the D-stage hazard unit combines with the D-stage XALU opcode to stall any multiply/divide-class instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5: cycles Busy stays high after the start cycle for MULT/MULTU.
- DIV_CYCLES, 10: cycles Busy stays high after the start cycle for DIV/DIVU.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- XALUOp_E  input  4  E-stage op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 treated as none.
- A  input  32  forwarded rs value (E stage).
- B  input  32  forwarded rt value (E stage).
- Start  output  1  high in a cycle where an op 1-4 is accepted.
- Busy  output  1  Start OR (cnt != 0).
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- XALU_out  output  32  HI when op=5, LO when op=6, else 0 (combinational).

Behaviour:
- One clock domain; all state updates on the rising edge of clk. Reset is synchronous and active-high, applied on the edge where reset=1.
- Reset values: HI=0, LO=0, cnt=0, pending_hi=0, pending_lo=0, pending_valid=0. After reset, Busy=0 and Start=0 (assuming XALUOp_E=0).
- States: IDLE (cnt==0) and RUN (cnt!=0). cnt is a 4-bit down-counter.
- Start = (XALUOp_E in 1..4) && cnt==0.
- On a Start edge:
  - Compute the result from A/B: 64-bit product, or quotient/remainder.
  - Latch it into pending_hi/pending_lo.
  - Set pending_valid=1, except for divide-by-zero.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
- RUN: cnt decrements by 1 each edge. On the edge where cnt goes 1->0, pending is committed to HI/LO if pending_valid, then pending_valid is cleared.
- Timing: the new HI/LO values are visible in the first cycle with cnt==0. Busy is high for N+1 consecutive cycles (start cycle plus N), N = MULT_CYCLES or DIV_CYCLES.
- MULT: signed 32x32 -> 64; HI=[63:32], LO=[31:0]. MULTU: the same, unsigned.
- DIV:
  - Signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned; LO=quotient, HI=remainder.
- Divide by zero (B==0): the full DIV_CYCLES latency still runs with Busy high; HI/LO are left unchanged.
- MTHI/MTLO:
  - Write A into HI/LO on the edge, only when cnt==0.
  - Ignored while in RUN; the hazard unit must have stalled it.
- MFHI/MFLO: combinational read of the current HI/LO through XALU_out; no state change.
- Op 1-4 arriving while cnt!=0: ignored (Start=0). This is a protocol violation; the bench flags it with an assertion.
- Back-to-back operations: a new op is accepted in the first cycle with cnt==0. The result of the earlier op has already been committed on that same edge, so the new op sees updated HI/LO.
- Reset mid-operation: cnt and pending are cleared and HI/LO are set to 0 on that edge. No commit of the aborted operation occurs.
- Invalid op codes 9-15: no effect, XALU_out=0.

Test Plan:
- Reset, then MULT A=0xFFFFFFFF B=0x00000002:
  - Start=1 for one cycle, Busy high for 6 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFE visible in cycle 6 after start.
  - HI/LO stay 0 before that cycle.
- MULTU A=0xFFFFFFFF B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV A=0xFFFFFFF9 (-7) B=2:
  - Busy for 11 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Edge cases in one run:
  - Preload HI=0x11, LO=0x22 via MTHI/MTLO.
  - DIVU A=7 B=0 -> Busy for 11 cycles; then HI=0x11, LO=0x22 unchanged.
  - MFLO -> XALU_out=0x22.
- Reset and overlap in one run:
  - MULT A=3 B=4, reset asserted on the 3rd busy cycle -> next cycle Busy=0, HI=LO=0; no later commit.
  - Repeat the MULT without reset, with MTLO A=0x55 issued during RUN -> ignored; LO=12 at completion.
